// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pkg
// Description : Shared types and constants for the pipelined immediate
//               extender: mode-select encoding and the PC increment used by
//               branch-target computation.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

  typedef logic [2:0] ext_sel_t;

  localparam ext_sel_t EXT_SA   = 3'b000;
  localparam ext_sel_t EXT_ZERO = 3'b001;
  localparam ext_sel_t EXT_SIGN = 3'b010;
  localparam ext_sel_t EXT_LUI  = 3'b011;
  localparam ext_sel_t EXT_BOFF = 3'b100;
  localparam ext_sel_t EXT_BTGT = 3'b101;

  localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe_if
// Description : Handshake bundle between decode and the immediate extender.
//               master = producer/consumer side (decode stage),
//               slave  = the extender block.
// Signals     : flush, in_valid/in_ready/in_imm/in_pc/ExtSel (input beat),
//               out_valid/out_ready/out_data/out_mode (result queue head)
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  import ext_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_pc;
  ext_sel_t          ExtSel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  ext_sel_t          out_mode;

  modport master (
    output flush, in_valid, in_imm, in_pc, ExtSel, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  flush, in_valid, in_imm, in_pc, ExtSel, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );

endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe_ext_unit.sv
`default_nettype none
// ============================================================================
// Module      : ext_unit
// Description : Combinational immediate extension / branch-target adder.
// Ports       : imm_i    - immediate field
//               pc_i     - instruction PC
//               sel_i    - extension mode
//               result_o - extended operand or branch target
// Revision    : 1.0 - initial release
// ============================================================================
module ext_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  ext_sel_t          sel_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_boff;

  assign w_sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign w_boff = {w_sext[DATA_W-3:0], 2'b00};

  always_comb begin
    result_o = w_sext;
    case (sel_i)
      EXT_SA:   result_o = {{(DATA_W-5){1'b0}}, imm_i[10:6]};
      EXT_ZERO: result_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
      EXT_SIGN: result_o = w_sext;
      EXT_LUI:  result_o = {imm_i, {(DATA_W-IMM_W){1'b0}}};
      EXT_BOFF: result_o = w_boff;
      // Branch target wraps silently at 2^DATA_W.
      EXT_BTGT: result_o = pc_i + DATA_W'(PC_INC) + w_boff;
      default:  result_o = w_sext;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Pipelined immediate extender. Each accepted beat is extended
//               by ext_unit and written into a first-word-fall-through queue
//               so decode can stall without losing results.
// Ports       : CLK   - rising-edge clock
//               RST_n - asynchronous active-low reset (clears queue storage)
//               bus   - imm_extend_pipe_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  imm_extend_pipe_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  ext_sel_t          mode_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_result;

  ext_unit #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_ext_unit (
    .imm_i    (bus.in_imm),
    .pc_i     (bus.in_pc),
    .sel_i    (bus.ExtSel),
    .result_o (w_result)
  );

  // in_ready depends only on count_q: a pop in a full cycle frees the slot
  // for the following cycle, keeping out_ready off the in_ready path.
  assign w_in_ready  = (count_q < CNT_W'(DEPTH));
  assign w_out_valid = (count_q != '0);
  assign w_push      = bus.in_valid && w_in_ready  && !bus.flush;
  assign w_pop       = w_out_valid  && bus.out_ready && !bus.flush;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_mode  = mode_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mode_q[i] <= EXT_SA;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_push) begin
        data_q[wr_ptr_q] <= w_result;
        mode_q[wr_ptr_q] <= bus.ExtSel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Directed self-checking bench for imm_extend_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;
  import ext_pkg::*;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int DEPTH  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

  imm_extend_pipe #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  // Single-beat vectors: mode, imm, pc, expected result.
  ext_sel_t    v_mode [7] = '{EXT_SIGN, EXT_ZERO, EXT_SA, EXT_LUI, EXT_BOFF, EXT_BTGT, EXT_BTGT};
  logic [15:0] v_imm  [7] = '{16'h8001, 16'h8001, 16'h07C0, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
  logic [31:0] v_pc   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'hFFFF_FFFC};
  logic [31:0] v_exp  [7] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_001F, 32'h1234_0000,
                              32'hFFFF_FFFC, 32'h0040_0000, 32'h0000_0000};

  // Streaming: imm=0x8044, pc=0x1000, modes 0..7.
  logic [31:0] s_exp [8] = '{32'h0000_0001, 32'h0000_8044, 32'hFFFF_8044, 32'h8044_0000,
                             32'hFFFE_0110, 32'hFFFE_1114, 32'hFFFF_8044, 32'hFFFF_8044};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input ext_sel_t m, input logic [15:0] imm, input logic [31:0] pc);
    bus.in_valid = v;
    bus.ExtSel   = m;
    bus.in_imm   = imm;
    bus.in_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, EXT_SA, 16'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data",  bus.out_data,       32'd0);
    check_eq("rst_out_mode",  32'(bus.out_mode),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Single beats, each visible one cycle after presentation
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, v_mode[i], v_imm[i], v_pc[i]);
      check_eq("single_pre_valid", 32'(bus.out_valid), 32'd0);
      check_eq("single_in_ready",  32'(bus.in_ready),  32'd1);
      step();
      drive(1'b0, EXT_SA, 16'h0, 32'h0);
      check_eq("single_valid", 32'(bus.out_valid), 32'd1);
      check_eq("single_data",  bus.out_data,       v_exp[i]);
      check_eq("single_mode",  32'(bus.out_mode),  32'(v_mode[i]));
      step();
      check_eq("single_drained", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: queue fills at two, third beat held
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_SIGN, 16'h0001, 32'h0);
    step();
    drive(1'b1, EXT_ZERO, 16'h0002, 32'h0);
    step();
    drive(1'b1, EXT_LUI, 16'h0003, 32'h0);
    check_eq("bp_full_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_eq("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    check_eq("bp_head_stable", bus.out_data, 32'h0000_0001);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_no_comb_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_eq("bp_pop1_data",  bus.out_data,      32'h0000_0002);
    check_eq("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, EXT_SA, 16'h0, 32'h0);
    check_eq("bp_third_data", bus.out_data,       32'h0003_0000);
    check_eq("bp_third_mode", 32'(bus.out_mode),  32'(EXT_LUI));
    step();
    check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming at one beat per cycle across all modes
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ext_sel_t'(i), 16'h8044, 32'h0000_1000);
      step();
      check_eq("stream_data",  bus.out_data,       s_exp[i]);
      check_eq("stream_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stream_ready", 32'(bus.in_ready),  32'd1);
    end
    drive(1'b0, EXT_SA, 16'h0, 32'h0);
    step();
    check_eq("stream_empty", 32'(bus.out_valid), 32'd0);

    // Flush with one entry and room available: flushed input not stored
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_SIGN, 16'h0011, 32'h0);
    step();
    drive(1'b1, EXT_ZERO, 16'h00BB, 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, EXT_SA, 16'h0, 32'h0);
    check_eq("flush1_valid", 32'(bus.out_valid), 32'd0);

    // Flush with two entries queued
    drive(1'b1, EXT_SIGN, 16'h0005, 32'h0);
    step();
    drive(1'b1, EXT_SIGN, 16'h0006, 32'h0);
    step();
    drive(1'b1, EXT_ZERO, 16'h00AA, 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_eq("flush2_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush2_ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, EXT_ZERO, 16'h0077, 32'h0);
    step();
    drive(1'b0, EXT_SA, 16'h0, 32'h0);
    check_eq("post_flush_data",  bus.out_data,       32'h0000_0077);
    check_eq("post_flush_valid", 32'(bus.out_valid), 32'd1);
    step();
    check_eq("post_flush_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_LUI, 16'h0009, 32'h0);
    step();
    drive(1'b0, EXT_SA, 16'h0, 32'h0);
    check_eq("pre_arst_data", bus.out_data, 32'h0009_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_data",  bus.out_data,       32'd0);
    check_eq("arst_mode",  32'(bus.out_mode),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("arst_rel_ready", 32'(bus.in_ready),  32'd1);
    check_eq("arst_rel_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check_eq("arst_no_ghost", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate extender for the MIPS datapath. It accepts an immediate field with a PC over a valid/ready handshake and computes the extended or derived operand for the selected mode. Results are buffered in a small first-word-fall-through output queue, so the decode stage can stall without losing work. It replaces the purely combinational extender between instruction decode and the ALU/PC-select logic.

Parameters:
DATA_W, 32, width of extended result and PC
IMM_W, 16, width of immediate input field; DATA_W >= 2*IMM_W
DEPTH, 2, output queue entries; power of two, >= 2

Ports:
CLK  input  1  rising-edge clock
RST_n  input  1  asynchronous active-low reset
flush  input  1  synchronous queue clear; drops the same-cycle input
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_imm  input  IMM_W  immediate field (instr[IMM_W-1:0])
in_pc  input  DATA_W  PC of the instruction
ExtSel  input  3  mode select, sampled with the input beat
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes the head entry
out_data  output  DATA_W  extended result
out_mode  output  3  ExtSel echoed with the result

Behaviour:
- Modes (value, result):
  - 000 SA: zero-extend in_imm[10:6].
  - 001 ZERO: zero-extend in_imm.
  - 010 SIGN: sign-extend in_imm.
  - 011 LUI: in_imm placed at bits [DATA_W-1:DATA_W-IMM_W]; lower bits are 0.
  - 100 BOFF: sign-extended in_imm shifted left by 2.
  - 101 BTGT: in_pc + 4 + BOFF, modulo 2^DATA_W. Wrap is silent.
  - 110/111: same as SIGN.
- Accept rule: a beat transfers on a rising edge when in_valid && in_ready && !flush. The result is computed combinationally from the inputs and written to the queue tail.
- in_ready = (count < DEPTH). It is derived only from registered state, with no combinational path from out_ready. When the queue is full and out_ready=1, in_ready stays 0 that cycle; the slot frees on the next cycle.
- Pop rule: the head pops on an edge when out_valid && out_ready && !flush.
- Output: first-word fall-through. out_valid = (count != 0). out_data/out_mode show the head entry.
- Latency: a beat accepted at edge k is visible on out_data at edge k (registered), i.e. one cycle after presentation. Throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- flush: on the edge, count, wr_ptr and rd_ptr are set to 0. Any push or pop in that cycle is ignored. out_valid is 0 the next cycle.
- Reset (RST_n low, at any time including mid-transfer):
  - count = 0, pointers = 0, out_valid = 0.
  - out_data = 0, out_mode = 000; queue storage is also cleared.
  - in_ready = 1 after reset release.
- out_data/out_mode must remain stable while out_valid && !out_ready.

Decomposition:
- Package ext_pkg holds:
  - mode constants EXT_SA, EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BOFF, EXT_BTGT;
  - typedef ext_sel_t (3 bits);
  - constant PC_INC = 4.
- Sub-module ext_unit: combinational mode decode/extension/adder, parametrised by DATA_W and IMM_W.
- The top level holds the queue and handshake logic.

Test Plan:
- Reset then single beats with out_ready=1:
  - SIGN 0x8001 -> 0xFFFF8001.
  - ZERO 0x8001 -> 0x00008001.
  - SA 0x07C0 -> 0x0000001F.
  - LUI 0x1234 -> 0x12340000.
  - Each appears one cycle after acceptance.
- BOFF 0xFFFF -> 0xFFFFFFFC. BTGT pc=0x00400000, imm=0xFFFF -> 0x00400000. BTGT pc=0xFFFFFFFC, imm=0x0000 -> 0x00000000 (wrap).
- Backpressure: out_ready=0, push 3 beats -> the first 2 are accepted and in_ready=0. The third is held with in_valid high. out_data stays at the first result. Raise out_ready -> results drain in order, with the third accepted one cycle after the first pop.
- Streaming: out_ready=1 and in_valid=1 for 8 cycles with modes cycling 000..111 -> 8 in-order results at 1/cycle, pointer wrap exercised, count never exceeds 1.
- Flush with 2 entries queued and in_valid=1 -> next cycle out_valid=0, count=0, the flushed input is not stored, and the next beat is accepted normally.
- Assert RST_n low asynchronously mid-stream (between edges) -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and the old entries never appear.
